axi4_ram: RTL and testbench

AXI4 full-protocol slave backed by a byte-addressable RAM, used as a memory-mapped target behind the Renode AXI manager in co-simulation. It accepts single and burst reads and writes (FIXED/INCR/WRAP) with byte strobes. It has independent read and write engines, one outstanding transaction per direction, and always responds OKAY. Storage is an inferred synchronous word array.

---
 rtl/axi4_ram_pkg.sv | 9 +
 rtl/axi4_ram_addr_next.sv | 25 ++
 rtl/axi4_ram.sv | 128 ++++++++++++
 tb/tb_axi4_ram.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_ram_pkg.sv
// axi4_ram_pkg: shared burst/response encodings and engine state types for axi4_ram
package axi4_ram_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
endpackage

// File: rtl/axi4_ram_addr_next.sv
// axi4_ram_addr_next: next beat address for FIXED/INCR/WRAP bursts, size clamped to bus width
module axi4_ram_addr_next import axi4_ram_pkg::*; #(
  parameter int ADDR_WIDTH = 20,
  parameter int STRB_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam int MAX_SIZE = $clog2(STRB_WIDTH);
  logic [2:0] eff_size;
  logic [ADDR_WIDTH-1:0] incr, bound, mask, sum;
  // wrap keeps the bits above the (len+1)*2^size window and cycles the bits inside it
  always_comb begin
    eff_size = size > 3'(MAX_SIZE) ? 3'(MAX_SIZE) : size;
    incr = ADDR_WIDTH'(1) << eff_size;
    bound = ADDR_WIDTH'({1'b0, len} + 9'd1) << eff_size;
    mask = bound - ADDR_WIDTH'(1);
    sum = addr + incr;
    next_addr = burst == BURST_FIXED ? addr :
                burst == BURST_WRAP ? (addr & ~mask) | (sum & mask) : sum;
  end
endmodule

// File: rtl/axi4_ram.sv
// axi4_ram: AXI4 slave over a byte-strobed word RAM with independent read and write engines
module axi4_ram import axi4_ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int ID_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int OFF = $clog2(STRB_WIDTH);
  localparam int WORDS = 2 ** (ADDR_WIDTH - OFF);
  logic [DATA_WIDTH-1:0] mem [WORDS];
  wr_state_t wr_state;
  rd_state_t rd_state;
  logic live;
  logic [ADDR_WIDTH-1:0] waddr, wnext, raddr, rnext;
  logic [7:0] wlen, wcnt, rlen, rcnt;
  logic [2:0] wsize, rsize;
  logic [1:0] wburst, rburst;
  logic unused;
  assign unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_wlast};
  assign s_axi_awready = live && wr_state == WR_IDLE;
  assign s_axi_wready = wr_state == WR_DATA;
  assign s_axi_bvalid = wr_state == WR_RESP;
  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_arready = live && rd_state == RD_IDLE;
  assign s_axi_rvalid = rd_state == RD_DATA;
  assign s_axi_rlast = s_axi_rvalid && rcnt == rlen;
  assign s_axi_rresp = RESP_OKAY;
  axi4_ram_addr_next #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_wr_next (
    .addr(waddr), .len(wlen), .size(wsize), .burst(wburst), .next_addr(wnext));
  axi4_ram_addr_next #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_rd_next (
    .addr(raddr), .len(rlen), .size(rsize), .burst(rburst), .next_addr(rnext));
  // holds the address channels off until the first edge after reset release
  always_ff @(posedge clk or posedge rst)
    if (rst) live <= 1'b0;
    else live <= 1'b1;
  // byte-lane writes into the RAM; no reset so the array stays a plain RAM
  always_ff @(posedge clk)
    if (s_axi_wvalid && s_axi_wready)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (s_axi_wstrb[i]) mem[waddr[ADDR_WIDTH-1:OFF]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
  // write engine: latch AW, count len+1 beats, then hold the B response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_state <= WR_IDLE;
      s_axi_bid <= '0;
      waddr <= '0;
      wlen <= '0;
      wcnt <= '0;
      wsize <= '0;
      wburst <= '0;
    end else if (s_axi_awvalid && s_axi_awready) begin
      wr_state <= WR_DATA;
      s_axi_bid <= s_axi_awid;
      waddr <= s_axi_awaddr;
      wlen <= s_axi_awlen;
      wcnt <= '0;
      wsize <= s_axi_awsize;
      wburst <= s_axi_awburst;
    end else if (s_axi_wvalid && s_axi_wready) begin
      waddr <= wnext;
      wcnt <= wcnt + 8'd1;
      if (wcnt == wlen) wr_state <= WR_RESP;
    end else if (s_axi_bvalid && s_axi_bready) wr_state <= WR_IDLE;
  // read engine: prefetch the first word on AR, fetch the next word on each R handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_state <= RD_IDLE;
      s_axi_rid <= '0;
      s_axi_rdata <= '0;
      raddr <= '0;
      rlen <= '0;
      rcnt <= '0;
      rsize <= '0;
      rburst <= '0;
    end else if (s_axi_arvalid && s_axi_arready) begin
      rd_state <= RD_DATA;
      s_axi_rid <= s_axi_arid;
      s_axi_rdata <= mem[s_axi_araddr[ADDR_WIDTH-1:OFF]];
      raddr <= s_axi_araddr;
      rlen <= s_axi_arlen;
      rcnt <= '0;
      rsize <= s_axi_arsize;
      rburst <= s_axi_arburst;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rdata <= mem[rnext[ADDR_WIDTH-1:OFF]];
      raddr <= rnext;
      rcnt <= rcnt + 8'd1;
      if (s_axi_rlast) rd_state <= RD_IDLE;
    end
endmodule

// File: tb/tb_axi4_ram.sv
// tb_axi4_ram: randomized and directed AXI4 traffic checked against a byte-level memory model
module tb_axi4_ram;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] awid = '0, arid = '0, awlen = '0, arlen = '0;
  logic [19:0] awaddr = '0, araddr = '0;
  logic [2:0] awsize = '0, arsize = '0, awprot = '0, arprot = '0;
  logic [1:0] awburst = '0, arburst = '0;
  logic [3:0] awcache = '0, arcache = '0, wstrb = '0;
  logic awlock = 1'b0, arlock = 1'b0, awvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [7:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mdl [int];
  logic [31:0] wq_d[$];
  logic [3:0] wq_s[$];
  logic [31:0] rq[$];

  axi4_ram dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // address of beat i straight from the burst rules, in closed form
  function automatic logic [19:0] beat_addr(input logic [19:0] a, input int len, input int sz, input int bu, input int i);
    int s = sz > 2 ? 2 : sz;
    int inc = 1 << s;
    int b = (len + 1) * inc;
    int ai = int'(a);
    if (bu == 0) return a;
    if (bu == 2) return 20'((ai & ~(b - 1)) | ((ai + i * inc) & (b - 1)));
    return 20'(ai + i * inc);
  endfunction

  task automatic mdl_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s);
    int base = int'(a) & ~3;
    for (int j = 0; j < 4; j++) if (s[j]) mdl[base + j] = d[j*8 +: 8];
  endtask

  task automatic exp_word(input logic [19:0] a, output logic [31:0] w, output logic [31:0] m);
    int base = int'(a) & ~3;
    w = '0;
    m = '0;
    for (int j = 0; j < 4; j++)
      if (mdl.exists(base + j)) begin
        w[j*8 +: 8] = mdl[base + j];
        m[j*8 +: 8] = 8'hFF;
      end
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [19:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    chk("aw_ready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("w_open", wready, 1);
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && n < 200) begin @(negedge clk); n++; end
    chk("w_ready", wready, 1);
    @(negedge clk);
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [19:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    aw_send(id, a, len, sz, bu);
    for (int i = 0; i <= int'(len); i++) begin
      w_beat(wq_d[i], wq_s[i], i == int'(len));
      mdl_write(beat_addr(a, len, sz, bu, i), wq_d[i], wq_s[i]);
    end
    chk("b_lat", bvalid, 1);
    bready = 1'b1;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    chk("b_id", bid, id);
    chk("b_resp", bresp, 0);
    @(negedge clk);
    bready = 1'b0;
    chk("aw_rearm", awready, 1);
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [19:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu, input logic toggle);
    int n = 0, i = 0;
    logic rr = 1'b1;
    logic [31:0] ew, em, hold;
    rq.delete();
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    chk("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("r_lat", rvalid, 1);
    n = 0;
    while (i <= int'(len) && n < 2000) begin
      rready = toggle ? rr : 1'b1;
      rr = ~rr;
      if (rvalid && rready) begin
        exp_word(beat_addr(a, len, sz, bu, i), ew, em);
        chk("r_data", rdata & em, ew);
        chk("r_last", rlast, i == int'(len));
        chk("r_id", rid, id);
        chk("r_resp", rresp, 0);
        rq.push_back(rdata);
        i++;
      end else if (rvalid) begin
        hold = rdata;
        @(negedge clk);
        n++;
        chk("r_stable", rdata, hold);
        chk("r_hold", rvalid, 1);
        continue;
      end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    chk("r_beats", i, int'(len) + 1);
    chk("ar_rearm", arready, 1);
  endtask

  task automatic fill(input int len, input logic [31:0] first, input logic rnd);
    wq_d.delete();
    wq_s.delete();
    for (int i = 0; i <= len; i++) begin
      wq_d.push_back(rnd ? $urandom : first + i);
      wq_s.push_back(rnd ? 4'($urandom) : 4'hF);
    end
  endtask

  initial begin
    logic [1:0] bu;
    logic [2:0] sz;
    logic [7:0] len;
    logic [19:0] a;
    repeat (3) @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid, rlast}, 0);
    chk("rst_ids", {bid, rid}, 0);
    chk("rst_data", rdata, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    rst = 1'b0;
    #1;
    chk("pre_edge_aw", awready, 0);
    @(negedge clk);
    chk("post_rst_ready", {awready, arready}, 2'b11);

    fill(0, 32'hDEADBEEF, 0);
    axi_write(8'h5A, 20'h00010, 0, 2, INCR);
    axi_read(8'h3C, 20'h00010, 0, 2, INCR, 0);
    chk("single", rq[0], 32'hDEADBEEF);

    fill(3, 1, 0);
    axi_write(8'h01, 20'h00100, 3, 2, INCR);
    axi_read(8'h02, 20'h00100, 3, 2, INCR, 0);
    chk("incr", {rq[0], rq[1], rq[2], rq[3]}, {32'd1, 32'd2, 32'd3, 32'd4});

    fill(0, 32'h11223344, 0);
    axi_write(8'h10, 20'h00200, 0, 2, INCR);
    wq_d[0] = 32'hAABBCCDD;
    wq_s[0] = 4'b0101;
    axi_write(8'h11, 20'h00200, 0, 2, INCR);
    axi_read(8'h12, 20'h00200, 0, 2, INCR, 0);
    chk("strobe", rq[0], 32'h11BB33DD);

    fill(3, 1, 0);
    axi_write(8'h20, 20'h00108, 3, 2, WRAP);
    axi_read(8'h21, 20'h00100, 3, 2, INCR, 1);
    chk("wrap", {rq[0], rq[1], rq[2], rq[3]}, {32'd3, 32'd4, 32'd1, 32'd2});

    axi_read(8'h22, 20'h00100, 3, 2, FIXED, 1);
    chk("fixed", {rq[0], rq[3]}, {32'd3, 32'd3});

    aw_send(8'h33, 20'h00300, 3, 2, INCR);
    w_beat(32'hA1, 4'hF, 0);
    mdl_write(20'h00300, 32'hA1, 4'hF);
    w_beat(32'hA2, 4'hF, 0);
    mdl_write(20'h00304, 32'hA2, 4'hF);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {awready, wready, arready}, 0);
    chk("mid_rst_valid", {bvalid, rvalid, rlast}, 0);
    chk("mid_rst_bid", bid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(0, 32'hCAFEF00D, 0);
    axi_write(8'h44, 20'h00300, 0, 2, INCR);
    axi_read(8'h45, 20'h00300, 1, 2, INCR, 0);
    chk("post_rst_w", rq[0], 32'hCAFEF00D);
    chk("partial_kept", rq[1], 32'hA2);

    for (int t = 0; t < 30; t++) begin
      bu = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 3));
      len = bu == WRAP ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
      a = 20'h00400 + 20'($urandom_range(0, 1023));
      fill(int'(len), 0, 1);
      axi_write(8'($urandom), a, len, sz, bu);
      if ($urandom_range(0, 1) == 0) begin
        bu = 2'($urandom_range(0, 3));
        sz = 3'($urandom_range(0, 3));
        len = bu == WRAP ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
        a = 20'h00400 + 20'($urandom_range(0, 1023));
      end
      axi_read(8'($urandom), a, len, sz, bu, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
